// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the default operand width.
package serial_alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full-adder cell stepped across the operands by serial_add_sequencer.
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer: one full-adder cell walked LSB-first, one bit per clock.
// Optional macro SERIAL_ADDER_SUB_EN adds the i_sub port (A-B computed as A + ~B + 1).
module serial_add_sequencer
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co,
  output logic             o_ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_co;
  logic             r_ovf;
  logic             w_sub;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH:0]   w_cat;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = i_sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_cat    = {w_s, r_res};

  serial_fa_cell u_fa (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = i_start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= i_a;
      r_b_sh  <= w_sub ? ~i_b : i_b;
      r_carry <= w_sub;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_c;
      r_res   <= w_cat[WIDTH:1];
      r_cnt   <= r_cnt + CNT_W'(1);
      // r_carry is still the carry into the MSB here, so it feeds the overflow term.
      if (w_last) begin
        r_sum <= w_cat[WIDTH:1];
        r_co  <= w_c;
        r_ovf <= r_carry ^ w_c;
      end
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);
  assign o_sum  = r_sum;
  assign o_co   = r_co;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=8 plus a WIDTH=1 instance); honours SERIAL_ADDER_SUB_EN.
module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, co, ovf;
  logic [7:0] sum;
  logic       start1, a1, b1, sub1;
  logic       busy1, done1, sum1, co1, ovf1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(sub),
`endif
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_co(co), .o_ovf(ovf)
  );

  serial_add_sequencer #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(sub1),
`endif
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_co(co1), .o_ovf(ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: two's-complement arithmetic on plain integers.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic msub,
                       output logic [7:0] s, output logic c, output logic v);
    int          full;
    int signed   sa, sb, sr;
    sa   = $signed(ma);
    sb   = $signed(mb);
    full = msub ? (int'(ma) + 256 - int'(mb)) : (int'(ma) + int'(mb));
    sr   = msub ? (sa - sb) : (sa + sb);
    s    = full[7:0];
    c    = full[8];
    v    = (sr > 127) || (sr < -128);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation; scramble operands after accept; report result, latency and busy cycles.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic osub,
                       output logic [7:0] s, output logic c, output logic v,
                       output int lat, output int busy_n);
    @(negedge clk);
    a = oa; b = ob; sub = osub; start = 1'b1;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    lat = 1; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    s = sum; c = co; v = ovf;
  endtask

  initial begin
    vec_t       vecs[$];
    logic [7:0] s, es, got;
    logic       c, v, ec, ev, rsub;
    int         lat, bn, nd, c1, c2, k;
    logic       hold_ok;

    rst_n = 1'b0; start = 0; a = 0; b = 0; sub = 0;
    start1 = 0; a1 = 0; b1 = 0; sub1 = 0;
    #12;
    check("reset_outputs", {busy, done, co, ovf, sum}, 12'h0);
    check("reset_outputs_w1", {busy1, done1, co1, ovf1, sum1}, 5'h0);
    @(negedge clk) rst_n = 1'b1;

    vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0});
`endif
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, s, c, v, lat, bn);
      check($sformatf("vec%0d_sum", i), s, vecs[i].s);
      check($sformatf("vec%0d_co", i), c, vecs[i].c);
      check($sformatf("vec%0d_ovf", i), v, vecs[i].v);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), bn, 8);
      tick();
      check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      a = 8'($urandom); b = 8'($urandom);
      model(a, b, rsub, es, ec, ev);
      do_op(a, b, rsub, s, c, v, lat, bn);
      check($sformatf("rand%0d_result", i), {s, c, v}, {es, ec, ev});
    end

    // START while busy must be ignored.
    @(negedge clk); a = 8'h12; b = 8'h34; sub = 0; start = 1;
    tick(); start = 0;
    nd = 0; got = 8'h00;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 1) begin start = 1; a = 8'h00; b = 8'h00; end
      if (j == 2) start = 0;
      if (done) begin nd++; got = sum; end
    end
    check("busy_start_done_count", nd, 1);
    check("busy_start_sum", got, 8'h46);

    // Async reset mid-run clears everything at once.
    @(negedge clk); a = 8'h33; b = 8'h22; start = 1;
    tick(); start = 0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check("midrun_reset", {busy, done, co, ovf, sum}, 12'h0);
    @(negedge clk) rst_n = 1'b1;
    do_op(8'h21, 8'h11, 1'b0, s, c, v, lat, bn);
    check("after_reset_op", {s, c, v, 8'(lat)}, {8'h32, 1'b0, 1'b0, 8'd9});

    // START held across DONE: back-to-back accept.
    @(negedge clk); a = 8'h10; b = 8'h20; sub = 0; start = 1;
    tick(); a = 8'h01; b = 8'h02;
    c1 = -1; c2 = -1; hold_ok = 1'b1; k = 1;
    while (c2 < 0 && k < 40) begin
      if (done) begin
        if (c1 < 0) c1 = k;
        else c2 = k;
      end
      if (c1 >= 0 && c2 < 0 && sum !== 8'h30) hold_ok = 1'b0;
      tick();
      if (c1 >= 0 && k == c1 + 1) start = 0;
      k++;
    end
    start = 0;
    check("b2b_done_spacing", c2 - c1, 9);
    check("b2b_sum_hold", hold_ok, 1'b1);
    check("b2b_second_sum", sum, 8'h03);

    // WIDTH=1 instance: 1+1 and 0+1.
    @(negedge clk); a1 = 1; b1 = 1; sub1 = 0; start1 = 1;
    tick(); start1 = 0; a1 = 0; b1 = 0;
    lat = 1;
    while (!done1 && lat < 10) begin tick(); lat++; end
    check("w1_latency", lat, 2);
    check("w1_result", {sum1, co1, ovf1}, 3'b011);
    @(negedge clk); a1 = 0; b1 = 1; start1 = 1;
    tick(); start1 = 0;
    lat = 1;
    while (!done1 && lat < 10) begin tick(); lat++; end
    check("w1_result2", {sum1, co1, ovf1, 4'(lat)}, {3'b100, 4'd2});

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
